conv_ram_sequencer: RTL

Multi-channel sequencer between the shared AXI-lite scratch RAM and the convolution engine. It loads each channel's KERNEL_SIZE² weights, streams that channel's DATA_SIZE² input pixels with engine backpressure, and writes engine results back to RAM at a programmable base and stride. Base addresses and channel count are run-time inputs captured on a start pulse. Completion is signalled by a drain-idle timeout rather than a fixed cycle count.

---
 rtl/conv_seq_pkg.sv | 20 ++
 rtl/conv_seq_rd_pipe.sv | 54 +++++
 rtl/conv_ram_sequencer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/conv_seq_pkg.sv
// rtl/conv_seq_pkg.sv - shared state encoding and size helpers for conv_ram_sequencer
package conv_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W_LOAD,
    ST_X_STREAM,
    ST_DRAIN,
    ST_DONE
  } seq_state_t;

  localparam int KERNEL_SIZE_DEF = 5;
  localparam int DATA_SIZE_DEF   = 32;

  // K2 and N2 are derived in the sequencer from its own KERNEL_SIZE/DATA_SIZE through this helper.
  function automatic int sq(input int edge_len);
    return edge_len * edge_len;
  endfunction

endpackage

// File: rtl/conv_seq_rd_pipe.sv
// rtl/conv_seq_rd_pipe.sv - one-cycle tag pipeline that aligns weight/pixel beats with RAM read data
module conv_seq_rd_pipe
  import conv_seq_pkg::*;
#(
  parameter int AXI_DATA_BW = 16,
  parameter int DATA_BW     = 8,
  parameter int WEIGHT_BW   = 8,
  parameter int ADDR_BW     = 5
) (
  input  logic                   ACLK,
  input  logic                   ARESETn,
  input  logic                   i_issue_w,
  input  logic                   i_issue_x,
  input  logic [ADDR_BW-1:0]     i_issue_idx,
  input  logic [AXI_DATA_BW-1:0] i_r_data,
  output logic                   o_w_valid,
  output logic [WEIGHT_BW-1:0]   o_w,
  output logic [ADDR_BW-1:0]     o_addr,
  output logic                   o_valid,
  output logic [DATA_BW-1:0]     o_x
);

  logic               w_vld_q, w_vld_d;
  logic               x_vld_q, x_vld_d;
  logic [ADDR_BW-1:0] idx_q, idx_d;
  logic               unused_rdata;

  always_comb begin
    w_vld_d = i_issue_w;
    x_vld_d = i_issue_x;
    idx_d   = i_issue_w ? i_issue_idx : '0;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_vld_q <= 1'b0;
      x_vld_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      w_vld_q <= w_vld_d;
      x_vld_q <= x_vld_d;
      idx_q   <= idx_d;
    end
  end

  // Data lanes are gated so the engine sees zeros whenever no beat is in flight.
  assign o_w_valid    = w_vld_q;
  assign o_w          = w_vld_q ? i_r_data[WEIGHT_BW-1:0] : '0;
  assign o_addr       = idx_q;
  assign o_valid      = x_vld_q;
  assign o_x          = x_vld_q ? i_r_data[DATA_BW-1:0] : '0;
  assign unused_rdata = ^i_r_data;

endmodule

// File: rtl/conv_ram_sequencer.sv
// rtl/conv_ram_sequencer.sv - per-channel weight load, pixel stream and result write-back sequencer
module conv_ram_sequencer
  import conv_seq_pkg::*;
#(
  parameter int AXI_ADDR_BW = 12,
  parameter int AXI_DATA_BW = 16,
  parameter int KERNEL_SIZE = KERNEL_SIZE_DEF,
  parameter int DATA_SIZE   = DATA_SIZE_DEF,
  parameter int DATA_BW     = 8,
  parameter int WEIGHT_BW   = 8,
  parameter int SUM_BW      = 16,
  parameter int ADDR_BW     = 5,
  parameter int CH_BW       = 4,
  parameter int CNT_BW      = 11,
  parameter int DRAIN_IDLE  = 16
) (
  input  logic                   ACLK,
  input  logic                   ARESETn,
  input  logic                   i_start,
  input  logic [CH_BW-1:0]       i_num_ch,
  input  logic [AXI_ADDR_BW-1:0] i_w_base,
  input  logic [AXI_ADDR_BW-1:0] i_x_base,
  input  logic [AXI_ADDR_BW-1:0] i_y_base,
  input  logic [AXI_ADDR_BW-1:0] i_y_stride,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [CH_BW-1:0]       o_ch,
  output logic                   o_r_en,
  output logic [AXI_ADDR_BW-1:0] o_r_addr,
  input  logic [AXI_DATA_BW-1:0] i_r_data,
  output logic                   o_w_en,
  output logic [AXI_ADDR_BW-1:0] o_w_addr,
  output logic [AXI_DATA_BW-1:0] o_w_data,
  output logic                   o_w_valid,
  output logic [WEIGHT_BW-1:0]   o_w,
  output logic [ADDR_BW-1:0]     o_addr,
  output logic                   o_valid,
  output logic [DATA_BW-1:0]     o_x,
  input  logic                   i_ready,
  input  logic                   i_valid,
  input  logic [SUM_BW-1:0]      i_y
);

  localparam int K2      = sq(KERNEL_SIZE);
  localparam int N2      = sq(DATA_SIZE);
  localparam int IDLE_BW = $clog2(DRAIN_IDLE + 1);
  localparam logic [ADDR_BW-1:0] LAST_W     = ADDR_BW'(K2 - 1);
  localparam logic [CNT_BW-1:0]  LAST_X     = CNT_BW'(N2 - 1);
  localparam logic [IDLE_BW-1:0] IDLE_LIMIT = IDLE_BW'(DRAIN_IDLE);

  seq_state_t             state_q, state_d;
  logic [CH_BW-1:0]       num_ch_q, num_ch_d;
  logic [CH_BW-1:0]       ch_q, ch_d;
  logic [AXI_ADDR_BW-1:0] y_stride_q, y_stride_d;
  logic [AXI_ADDR_BW-1:0] waddr_q, waddr_d;
  logic [AXI_ADDR_BW-1:0] xaddr_q, xaddr_d;
  logic [AXI_ADDR_BW-1:0] yaddr_q, yaddr_d;
  logic                   done_q, done_d;
  logic [ADDR_BW-1:0]     wcnt_q, wcnt_d;
  logic [CNT_BW-1:0]      issued_q, issued_d;
  logic [IDLE_BW-1:0]     idle_q, idle_d;

  logic                   start_ok;
  logic                   rd_en, issue_w, issue_x, wr_en;
  logic [AXI_ADDR_BW-1:0] rd_addr;
  logic [IDLE_BW-1:0]     idle_next;

  assign start_ok = i_start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  always_comb begin
    state_d    = state_q;
    num_ch_d   = num_ch_q;
    ch_d       = ch_q;
    y_stride_d = y_stride_q;
    waddr_d    = waddr_q;
    xaddr_d    = xaddr_q;
    yaddr_d    = yaddr_q;
    done_d     = done_q;
    wcnt_d     = wcnt_q;
    issued_d   = issued_q;
    idle_d     = idle_q;
    rd_en      = 1'b0;
    rd_addr    = '0;
    issue_w    = 1'b0;
    issue_x    = 1'b0;
    wr_en      = 1'b0;
    idle_next  = i_valid ? '0 : idle_q + IDLE_BW'(1);

    case (state_q)
      ST_W_LOAD: begin
        rd_en   = 1'b1;
        rd_addr = waddr_q;
        issue_w = 1'b1;
        waddr_d = waddr_q + AXI_ADDR_BW'(1);
        if (wcnt_q == LAST_W) begin
          wcnt_d   = '0;
          issued_d = '0;
          state_d  = ST_X_STREAM;
        end else begin
          wcnt_d = wcnt_q + ADDR_BW'(1);
        end
      end
      ST_X_STREAM: begin
        if (i_ready && (issued_q <= LAST_X)) begin
          rd_en    = 1'b1;
          rd_addr  = xaddr_q;
          issue_x  = 1'b1;
          xaddr_d  = xaddr_q + AXI_ADDR_BW'(1);
          issued_d = issued_q + CNT_BW'(1);
          if (issued_q == LAST_X) begin
            if (ch_q != num_ch_q - CH_BW'(1)) begin
              ch_d    = ch_q + CH_BW'(1);
              state_d = ST_W_LOAD;
            end else begin
              idle_d  = '0;
              state_d = ST_DRAIN;
            end
          end
        end
      end
      ST_DRAIN: begin
        idle_d = idle_next;
        if (idle_next == IDLE_LIMIT) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      default: ;
    endcase

    // Results are written in every active state, including the cycle of a state change.
    if (i_valid && (state_q != ST_IDLE)) begin
      wr_en   = 1'b1;
      yaddr_d = yaddr_q + y_stride_q;
    end

    if (start_ok) begin
      num_ch_d   = (i_num_ch == '0) ? CH_BW'(1) : i_num_ch;
      y_stride_d = i_y_stride;
      waddr_d    = i_w_base;
      xaddr_d    = i_x_base;
      yaddr_d    = i_y_base;
      ch_d       = '0;
      done_d     = 1'b0;
      wcnt_d     = '0;
      issued_d   = '0;
      idle_d     = '0;
      state_d    = ST_W_LOAD;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q    <= ST_IDLE;
      num_ch_q   <= '0;
      ch_q       <= '0;
      y_stride_q <= '0;
      waddr_q    <= '0;
      xaddr_q    <= '0;
      yaddr_q    <= '0;
      done_q     <= 1'b0;
      wcnt_q     <= '0;
      issued_q   <= '0;
      idle_q     <= '0;
    end else begin
      state_q    <= state_d;
      num_ch_q   <= num_ch_d;
      ch_q       <= ch_d;
      y_stride_q <= y_stride_d;
      waddr_q    <= waddr_d;
      xaddr_q    <= xaddr_d;
      yaddr_q    <= yaddr_d;
      done_q     <= done_d;
      wcnt_q     <= wcnt_d;
      issued_q   <= issued_d;
      idle_q     <= idle_d;
    end
  end

  conv_seq_rd_pipe #(
    .AXI_DATA_BW (AXI_DATA_BW),
    .DATA_BW     (DATA_BW),
    .WEIGHT_BW   (WEIGHT_BW),
    .ADDR_BW     (ADDR_BW)
  ) u_rd_pipe (
    .ACLK        (ACLK),
    .ARESETn     (ARESETn),
    .i_issue_w   (issue_w),
    .i_issue_x   (issue_x),
    .i_issue_idx (wcnt_q),
    .i_r_data    (i_r_data),
    .o_w_valid   (o_w_valid),
    .o_w         (o_w),
    .o_addr      (o_addr),
    .o_valid     (o_valid),
    .o_x         (o_x)
  );

  assign o_busy   = (state_q == ST_W_LOAD) || (state_q == ST_X_STREAM) || (state_q == ST_DRAIN);
  assign o_done   = done_q;
  assign o_ch     = ch_q;
  assign o_r_en   = rd_en;
  assign o_r_addr = rd_addr;
  assign o_w_en   = wr_en;
  assign o_w_addr = wr_en ? yaddr_q : '0;
  assign o_w_data = wr_en ? AXI_DATA_BW'(i_y) : '0;

endmodule
